// File: rtl/sin_meas_pkg.sv
// Shared types and default sizing for the sine period measurement block.
//   state_t : measurement FSM states
//   DEF_*   : default parameter values used by sin_period_meas / sin_zc_det
package sin_meas_pkg;

  localparam int unsigned DEF_DATA_W     = 9;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_HYST       = 8;
  localparam int unsigned DEF_LOG2_NAVG  = 2;
  localparam int unsigned DEF_MAX_PERIOD = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    SEEK    = 2'd2,
    MEASURE = 2'd3
  } state_t;

endpackage

// File: rtl/sin_zc_det.sv
// Hysteretic threshold compare for the rising zero-crossing detector.
// Purely combinational; the armed flag itself lives in the parent.
//   sample_i   : signed sample under test
//   armed_i    : a low sample has been seen since the last crossing
//   is_low_c   : sample_i <= -HYST
//   is_high_c  : sample_i >= +HYST
//   crossing_c : high sample while armed (true rising edge)
module sin_zc_det
  import sin_meas_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned HYST   = DEF_HYST
) (
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic                     armed_i,
  output logic                     is_low_c,
  output logic                     is_high_c,
  output logic                     crossing_c
);

  localparam logic signed [DATA_W-1:0] POS_TH = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] NEG_TH = -POS_TH;

  // Both compares are signed.
  assign is_low_c   = (sample_i <= NEG_TH);
  assign is_high_c  = (sample_i >= POS_TH);
  assign crossing_c = is_high_c & armed_i;

endmodule

// File: rtl/sin_period_meas.sv
// Sine sample-stream period / amplitude measurement.
// Detects hysteretic rising zero crossings, averages 2**LOG2_NAVG periods
// (in accepted samples) and reports the average period and the window peak.
//   clk, resetb : clock, asynchronous active-low reset
//   en          : measurement enable, low returns to IDLE every cycle
//   in_valid    : qualifies in_sample; invalid cycles freeze all state
//   in_sample   : signed sample
//   period_out  : averaged period in samples (held until the next result)
//   amp_out     : non-negative peak sample of the last averaging window
//   meas_valid  : one-cycle pulse with each new result
//   locked      : set by a result, cleared by timeout or en low
//   timeout     : one-cycle pulse when the period counter hits MAX_PERIOD
module sin_period_meas
  import sin_meas_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned HYST       = DEF_HYST,
  parameter int unsigned LOG2_NAVG  = DEF_LOG2_NAVG,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic [CNT_W-1:0]         period_out,
  output logic [DATA_W-1:0]        amp_out,
  output logic                     meas_valid,
  output logic                     locked,
  output logic                     timeout
);

  localparam int unsigned ACC_W  = CNT_W + LOG2_NAVG;
  localparam int unsigned PN_W   = LOG2_NAVG + 1;
  localparam int unsigned CNT_W1 = CNT_W + 1;

  localparam logic [PN_W-1:0]   NAVG    = PN_W'(1 << LOG2_NAVG);
  localparam logic [CNT_W1-1:0] MAX_CNT = CNT_W1'(MAX_PERIOD);

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [PN_W-1:0]            per_n_q, per_n_d;
  logic signed [DATA_W-1:0]   peak_q, peak_d;
  logic                       armed_q, armed_d;
  logic [CNT_W-1:0]           period_q, period_d;
  logic [DATA_W-1:0]          amp_q, amp_d;
  logic                       meas_valid_q, meas_valid_d;
  logic                       locked_q, locked_d;
  logic                       timeout_q, timeout_d;

  logic                       is_low_c;
  logic                       is_high_c;
  logic                       crossing_c;

  logic [CNT_W1-1:0]          cnt_inc_c;
  logic                       cnt_hit_c;
  logic [ACC_W-1:0]           acc_sum_c;
  logic [PN_W-1:0]            per_n_inc_c;
  logic signed [DATA_W-1:0]   peak_upd_c;

  // Threshold compare and crossing qualification.
  sin_zc_det #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_zc_det (
    .sample_i   (in_sample),
    .armed_i    (armed_q),
    .is_low_c   (is_low_c),
    .is_high_c  (is_high_c),
    .crossing_c (crossing_c)
  );

  // Arithmetic shared by the FSM branches.
  assign cnt_inc_c   = {1'b0, cnt_q} + CNT_W1'(1);
  assign cnt_hit_c   = (cnt_inc_c == MAX_CNT);
  assign acc_sum_c   = acc_q + ACC_W'(cnt_q);
  assign per_n_inc_c = per_n_q + PN_W'(1);
  assign peak_upd_c  = smax(peak_q, in_sample);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    per_n_d      = per_n_q;
    peak_d       = peak_q;
    armed_d      = armed_q;
    period_d     = period_q;
    amp_d        = amp_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = 1'b0;

    if (!en) begin
      // Disable discards any partial window; results hold.
      state_d  = IDLE;
      cnt_d    = '0;
      acc_d    = '0;
      per_n_d  = '0;
      peak_d   = '0;
      armed_d  = 1'b0;
      locked_d = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
        end

        // Wait for a low sample so the first crossing is a real rising edge.
        ARM: begin
          if (is_low_c) begin
            state_d = SEEK;
            cnt_d   = CNT_W'(1);
          end
        end

        SEEK: begin
          if (is_high_c) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            acc_d   = '0;
            per_n_d = '0;
            peak_d  = in_sample;
            armed_d = 1'b0;
          end else if (cnt_hit_c) begin
            state_d   = ARM;
            cnt_d     = '0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc_c[CNT_W-1:0];
          end
        end

        MEASURE: begin
          if (crossing_c) begin
            // The crossing sample starts the next period (cnt restarts at 1).
            cnt_d   = CNT_W'(1);
            armed_d = 1'b0;
            if (per_n_inc_c == NAVG) begin
              period_d     = CNT_W'(acc_sum_c >> LOG2_NAVG);
              amp_d        = peak_q[DATA_W-1] ? '0 : $unsigned(peak_q);
              meas_valid_d = 1'b1;
              locked_d     = 1'b1;
              acc_d        = '0;
              per_n_d      = '0;
              peak_d       = in_sample;
            end else begin
              acc_d   = acc_sum_c;
              per_n_d = per_n_inc_c;
              peak_d  = peak_upd_c;
            end
          end else if (cnt_hit_c) begin
            state_d   = ARM;
            cnt_d     = '0;
            acc_d     = '0;
            per_n_d   = '0;
            armed_d   = 1'b0;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
          end else begin
            cnt_d   = cnt_inc_c[CNT_W-1:0];
            peak_d  = peak_upd_c;
            armed_d = armed_q | is_low_c;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      per_n_q      <= '0;
      peak_q       <= '0;
      armed_q      <= 1'b0;
      period_q     <= '0;
      amp_q        <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      per_n_q      <= per_n_d;
      peak_q       <= peak_d;
      armed_q      <= armed_d;
      period_q     <= period_d;
      amp_q        <= amp_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign amp_out    = amp_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
